bitserial_sum_collector: RTL and testbench
==========================================

# bitserial_sum_collector

Serial-to-parallel stage placed directly downstream of the bit-serial adder. It captures the adder's LSB-first `q` stream into a `WIDTH`-bit parallel sum and presents the result on a valid/ready output port. The serial stream has no backpressure, so the block double-buffers: one frame is collected while the previous result waits to be taken. A result that cannot be stored is flagged as an overrun.

## Interface
- `WIDTH`, default 8: sum width in bits; legal range is 2 or more.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  serial sum bit from the adder `q`, LSB first.
- `bit_valid`  in  1  `bit_in` carries a frame bit this cycle.
- `first`  in  1  qualifies `bit_valid`; marks bit 0 of a frame.
- `sum`  out  `WIDTH`  collected sum, stable while `out_valid` is high.
- `out_valid`  out  1  `sum` holds an untaken result.
- `out_ready`  in  1  consumer accepts `sum` when `out_valid && out_ready`.
- `busy`  out  1  a frame is partially collected (state COLLECT).
- `frame_err`  out  1  one-cycle pulse when a frame is restarted mid-collection.
- `overrun`  out  1  sticky flag: a completed frame was dropped.

## Operation
- `NBITS` equals `WIDTH`, or `WIDTH+1` with the carry feature enabled. The counter width is clog2(`NBITS`+1).
- Shift register `sh` fills LSB-first: a bit captured at index k lands in `sh[k]`.
- FSM states:
  - IDLE:
    - `bit_valid && first`: capture bit 0, count=1, go to COLLECT.
    - `bit_valid` without `first`: ignore the bit (no flag).
  - COLLECT, `bit_valid` low: hold state. Gaps of any length are allowed.
  - COLLECT, `bit_valid && first`:
    - Discard the partial frame.
    - Capture this bit as bit 0, count=1.
    - Pulse `frame_err`.
  - COLLECT, `bit_valid && !first` with count < `NBITS`-1: capture bit, count+1.
  - COLLECT, `bit_valid && !first` with count = `NBITS`-1: capture the last bit and complete the frame, then go to IDLE.
- On completion:
  - If the output register is free, or is drained by `out_valid && out_ready` in the same cycle, load `sum` and set `out_valid`.
  - Otherwise drop the new frame, keep the old `sum`, and set `overrun`.
- `out_valid` clears on `out_valid && out_ready` unless a completion reloads it in the same cycle.
- `overrun` clears only on reset.
- Reset values: state IDLE, count 0, `sh` 0, `sum` 0, `out_valid` 0, `busy` 0, `frame_err` 0, `overrun` 0.
- Reset mid-frame discards the partial frame and any held result.

## Timing
- All outputs are registered.
- `out_valid` and `sum` update the cycle after the final bit's clock edge. This is 1 cycle of latency after the last bit.
- Minimum frame time is `NBITS` consecutive cycles. Back-to-back frames are supported: `first` may assert the cycle after the last bit.
- `busy` rises the cycle after bit 0 is captured and falls the cycle after the last bit.
- `frame_err` is high for exactly the one cycle after the restarting edge.
- `out_ready` is ignored while `out_valid` is low.

## Configuration
- Macro `BITSERIAL_SUM_CARRY_EN`.
- Defined:
  - `NBITS`=`WIDTH`+1.
  - Extra output `cout` (1 bit, reset 0) carries collected bit `WIDTH`, which is the adder carry flushed by one a=b=0 cycle.
  - `cout` is loaded and held together with `sum`.
- Undefined:
  - `NBITS`=`WIDTH`.
  - No `cout` port.
  - The carry is discarded by the upstream framing.

## Test plan
- `WIDTH`=8, no macro: feed 0x8D LSB-first (1,0,1,1,0,0,0,1), `first` on bit 0, `out_ready`=1 → `out_valid` for 1 cycle starting the cycle after bit 7, `sum`=8'h8D.
- Macro defined: feed 0xFF+0x01 result bits (0×8 then carry 1) → `sum`=8'h00, `cout`=1, `out_valid` the cycle after the 9th bit.
- Gaps: 0x3C with `bit_valid` low for 2 cycles between each bit → `sum`=8'h3C, `busy` high throughout, no `frame_err`.
- Restart: 4 bits of a frame, then `first` with full 0xA5 frame → `frame_err` pulses once, `sum`=8'hA5.
- Overrun: `out_ready`=0, two back-to-back frames 0x11 then 0x22 → `sum` stays 8'h11, `overrun`=1 after second frame; then `out_ready`=1 → `out_valid` drops, `overrun` stays 1.
- Reset: assert `reset` low after bit 5 with a result pending → all outputs 0 immediately (async), next full frame 0x7E captured normally.

Source files
------------

// File: rtl/bitserial_sum_collector.sv
// bitserial_sum_collector: LSB-first serial-to-parallel capture with a double-buffered valid/ready result.
// Define BITSERIAL_SUM_CARRY_EN to collect one extra carry bit into cout.
module bitserial_sum_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             first,
  output logic [WIDTH-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
`ifdef BITSERIAL_SUM_CARRY_EN
  output logic             cout,
`endif
  output logic             overrun
);
`ifdef BITSERIAL_SUM_CARRY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t          state;
  logic [CW-1:0]   count, idx;
  logic [NBITS-1:0] sh, sh_next;
  logic            start, take, done;
  always_comb begin
    start   = bit_valid && first;
    take    = bit_valid && !first && state == COLLECT;
    done    = take && count == CW'(NBITS - 1);
    idx     = start ? '0 : count;
    sh_next = start ? '0 : sh;
    for (int i = 0; i < NBITS; i++)
      if ((start || take) && i == int'(idx)) sh_next[i] = bit_in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      sh        <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef BITSERIAL_SUM_CARRY_EN
      cout      <= 1'b0;
`endif
    end else begin
      frame_err <= start && state == COLLECT;
      if (start || take) sh <= sh_next;
      if (start) begin
        state <= COLLECT;
        count <= CW'(1);
        busy  <= 1'b1;
      end else if (done) begin
        state <= IDLE;
        count <= '0;
        busy  <= 1'b0;
      end else if (take) count <= count + CW'(1);
      // A completed frame may reuse the output slot only if it is empty or drained this cycle
      if (done && (!out_valid || out_ready)) begin
        sum       <= sh_next[WIDTH-1:0];
        out_valid <= 1'b1;
`ifdef BITSERIAL_SUM_CARRY_EN
        cout      <= sh_next[WIDTH];
`endif
      end else begin
        if (done) overrun <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bitserial_sum_collector.sv
// tb_bitserial_sum_collector: directed and random frames checked against a frame-level reference model.
module tb_bitserial_sum_collector;
  localparam int W = 8;
`ifdef BITSERIAL_SUM_CARRY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk = 0, reset = 0, bit_in = 0, bit_valid = 0, first = 0, out_ready = 0;
  logic [W-1:0] sum;
  logic out_valid, busy, frame_err, overrun, cout_dut;
  int checks = 0, errors = 0;
  int m_k = -1;
  longint unsigned m_val = 0;
  logic [W-1:0] m_sum = '0;
  logic m_cout = 0, m_ov = 0, m_over = 0, m_fe = 0;

  bitserial_sum_collector #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .first(first),
    .sum(sum), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_err(frame_err),
`ifdef BITSERIAL_SUM_CARRY_EN
    .cout(cout_dut),
`endif
    .overrun(overrun)
  );
`ifndef BITSERIAL_SUM_CARRY_EN
  assign cout_dut = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("sum", 32'(sum), 32'(m_sum));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_k >= 0));
    chk("frame_err", 32'(frame_err), 32'(m_fe));
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("cout", 32'(cout_dut), 32'(m_cout));
  endtask

  task automatic model_reset();
    m_k = -1; m_val = 0; m_sum = '0; m_cout = 0; m_ov = 0; m_over = 0; m_fe = 0;
  endtask

  task automatic step(input logic bv, input logic f, input logic b, input logic rdy);
    logic completed;
    bit_valid = bv; first = f; bit_in = b; out_ready = rdy;
    @(posedge clk);
    completed = 0;
    m_fe = 0;
    if (bv && f) begin
      m_fe = (m_k >= 0);
      m_k = 1;
      m_val = longint'(b);
    end else if (bv && m_k >= 0) begin
      m_val |= longint'(b) << m_k;
      m_k++;
      if (m_k == NB) begin completed = 1; m_k = -1; end
    end
    if (completed && (!m_ov || rdy)) begin
      m_sum = m_val[W-1:0];
`ifdef BITSERIAL_SUM_CARRY_EN
      m_cout = m_val[W];
`endif
      m_ov = 1;
    end else begin
      if (completed) m_over = 1;
      if (m_ov && rdy) m_ov = 0;
    end
    #1;
    chk_all();
  endtask

  task automatic frame(input logic [NB-1:0] v, input int gap, input logic rdy);
    for (int k = 0; k < NB; k++) begin
      step(1'b1, k == 0, v[k], rdy);
      if (k != NB - 1) repeat (gap) step(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  initial begin
    #2;
    chk_all();
    chk("reset_sum", 32'(sum), 32'h0);
    reset = 1;
    step(0, 0, 0, 1);
    // 0x8D with ready held high: valid for exactly one cycle
    frame(NB'(8'h8D), 0, 1);
    chk("sum_8d", 32'(sum), 32'h8D);
    chk("ov_8d", 32'(out_valid), 32'h1);
    step(0, 0, 0, 1);
    chk("ov_8d_drop", 32'(out_valid), 32'h0);
`ifdef BITSERIAL_SUM_CARRY_EN
    frame(9'h100, 0, 1);
    chk("sum_carry", 32'(sum), 32'h00);
    chk("cout_carry", 32'(cout_dut), 32'h1);
    step(0, 0, 0, 1);
`endif
    // gapped frame
    frame(NB'(8'h3C), 2, 1);
    chk("sum_3c", 32'(sum), 32'h3C);
    step(0, 0, 0, 1);
    // restart after 4 bits
    for (int k = 0; k < 4; k++) step(1, k == 0, 1'(k & 1), 1);
    frame(NB'(8'hA5), 0, 1);
    chk("sum_a5", 32'(sum), 32'hA5);
    step(0, 0, 0, 1);
    // overrun with no consumer
    frame(NB'(8'h11), 0, 0);
    frame(NB'(8'h22), 0, 0);
    chk("sum_hold_11", 32'(sum), 32'h11);
    chk("overrun_set", 32'(overrun), 32'h1);
    step(0, 0, 0, 1);
    chk("ov_drained", 32'(out_valid), 32'h0);
    chk("overrun_sticky", 32'(overrun), 32'h1);
    // reset mid-frame with a result pending
    frame(NB'(8'h55), 0, 0);
    for (int k = 0; k < 6; k++) step(1, k == 0, 1'(k % 3 == 0), 0);
    bit_valid = 0; first = 0;
    reset = 0;
    #1;
    model_reset();
    chk_all();
    chk("rst_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    reset = 1;
    frame(NB'(8'h7E), 0, 1);
    chk("sum_7e", 32'(sum), 32'h7E);
    // random traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, 1'($urandom), $urandom_range(0, 9) < 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
